// File: rtl/data_io_ram_pkg.sv
// Shared constants, download state encoding and lane helpers for the
// io-controller file-download client.
package data_io_pkg;

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

    // IDLE: no download; ACTIVE: accepting data; DRAIN: end seen, RAM still busy
    typedef enum logic [1:0] {
        DL_IDLE,
        DL_ACTIVE,
        DL_DRAIN
    } dl_state_t;

    // Number of byte lanes in a RAM word
    function automatic int unsigned lane_count(input int unsigned dw);
        return dw / 8;
    endfunction

    // Width of the lane counter (at least one bit, even for a single lane)
    function automatic int unsigned lane_width(input int unsigned dw);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 8; i++) begin
            if ((32'd1 << i) < lane_count(dw)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/data_io_ram_fifo.sv
// Single-clock word FIFO; a push while full is accepted when a pop frees
// the slot in the same cycle.
module data_io_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign dout  = mem_q[rd_ptr_q];

    // Pointer/count update and storage write
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // Pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/data_io_ram.sv
// io-controller file-download client: oversampled SPI receiver, byte packer
// into DW-wide words, and a FIFO-buffered req/ack RAM writer.
module data_io_ram
    import data_io_pkg::*;
#(
    parameter int unsigned   DW         = 16,
    parameter int unsigned   AW         = 25,
    parameter logic [AW-1:0] BASE       = AW'(32'hA0000),
    parameter int unsigned   IDX_W      = 5,
    parameter int unsigned   FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    output logic              downloading,
    output logic [AW-1:0]     size,
    output logic [IDX_W-1:0]  index,
    output logic              overrun,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [AW-1:0]     a,
    output logic [DW-1:0]     d,
    output logic [DW/8-1:0]   be
);

    localparam int unsigned       LANES      = lane_count(DW);
    localparam int unsigned       LANE_W     = lane_width(DW);
    localparam logic [LANE_W-1:0] LANE_TOP   = LANE_W'(LANES - 1);
    localparam logic [AW-1:0]     ALIGN_MASK = ~AW'(LANES - 1);

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        logic [LANES-1:0] be;
    } fifo_entry_t;

    logic [2:0]        sck_q, sck_d;
    logic [1:0]        ss_q, ss_d, sdi_q, sdi_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        sr_q, sr_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        rx_byte;
    logic              sck_rise, byte_valid;
    dl_state_t         state_q, state_d;
    logic [AW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DW-1:0]     word_q, word_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              overrun_q, overrun_d;
    logic              wr_req_q, wr_req_d;
    logic [AW-1:0]     a_q, a_d;
    logic [DW-1:0]     d_q, d_d;
    logic [LANES-1:0]  be_q, be_d;
    logic [LANES-1:0]  be_partial;
    logic [AW-1:0]     word_addr;
    fifo_entry_t       push_entry, pop_entry;
    logic              push, pop, fifo_full, fifo_empty;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign rx_byte   = {sr_q, sdi_q[1]};
    assign word_addr = BASE + (byte_cnt_q & ALIGN_MASK);

    // SPI synchronisers, bit counter, shift register and command capture
    always_comb begin
        sck_d      = {sck_q[1:0], sck};
        ss_d       = {ss_q[0], ss};
        sdi_d      = {sdi_q[0], sdi};
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        cmd_d      = cmd_q;
        byte_valid = 1'b0;
        if (ss_q[1]) begin
            bit_cnt_d = '0;
            cmd_d     = '0;
        end else if (sck_rise) begin
            sr_d = rx_byte[6:0];
            if (bit_cnt_q == 4'd7) cmd_d = rx_byte;
            if (bit_cnt_q == 4'd15) begin
                bit_cnt_d  = 4'd8;
                byte_valid = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    // Byte enables covering only the lanes filled so far
    always_comb begin
        be_partial = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            be_partial[i] = (LANE_W'(i) < lane_q);
        end
    end

    // Download state, byte packing and FIFO push
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        lane_d     = lane_q;
        word_d     = word_q;
        index_d    = index_q;
        overrun_d  = overrun_q;
        push       = 1'b0;
        push_entry = '0;
        if (state_q == DL_DRAIN && fifo_empty && !wr_req_q) state_d = DL_IDLE;
        if (byte_valid) begin
            case (cmd_q)
                CMD_FILE_TX: begin
                    if (rx_byte[0]) begin
                        state_d    = DL_ACTIVE;
                        byte_cnt_d = '0;
                        lane_d     = '0;
                        word_d     = '0;
                        overrun_d  = 1'b0;
                    end else if (state_q == DL_ACTIVE) begin
                        state_d = DL_DRAIN;
                        if (lane_q != '0) begin
                            push       = 1'b1;
                            push_entry = '{a: word_addr, d: word_q, be: be_partial};
                        end
                    end
                end
                CMD_FILE_TX_DAT: begin
                    if (state_q == DL_ACTIVE) begin
                        word_d[{lane_q, 3'b000} +: 8] = rx_byte;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (lane_q == LANE_TOP) begin
                            push       = 1'b1;
                            push_entry = '{a: word_addr, d: word_d, be: '1};
                            word_d     = '0;
                            lane_d     = '0;
                        end else begin
                            lane_d = lane_q + 1'b1;
                        end
                    end
                end
                CMD_FILE_INDEX: index_d = IDX_W'(rx_byte);
                default: ;
            endcase
        end
        if (push && fifo_full && !pop) overrun_d = 1'b1;
    end

    // RAM writer: load from the FIFO when idle or when the current word is acked
    always_comb begin
        pop      = !fifo_empty && (!wr_req_q || wr_ack);
        wr_req_d = wr_req_q;
        a_d      = a_q;
        d_d      = d_q;
        be_d     = be_q;
        if (pop) begin
            wr_req_d = 1'b1;
            a_d      = pop_entry.a;
            d_d      = pop_entry.d;
            be_d     = pop_entry.be;
        end else if (wr_req_q && wr_ack) begin
            wr_req_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q      <= '0;
            ss_q       <= '1;
            sdi_q      <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            cmd_q      <= '0;
            state_q    <= DL_IDLE;
            byte_cnt_q <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            index_q    <= '0;
            overrun_q  <= 1'b0;
            wr_req_q   <= 1'b0;
            a_q        <= BASE;
            d_q        <= '0;
            be_q       <= '0;
        end else begin
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            sdi_q      <= sdi_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            cmd_q      <= cmd_d;
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            index_q    <= index_d;
            overrun_q  <= overrun_d;
            wr_req_q   <= wr_req_d;
            a_q        <= a_d;
            d_q        <= d_d;
            be_q       <= be_d;
        end
    end

    data_io_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (pop_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign downloading = (state_q != DL_IDLE);
    assign size        = byte_cnt_q;
    assign index       = index_q;
    assign overrun     = overrun_q;
    assign wr_req      = wr_req_q;
    assign a           = a_q;
    assign d           = d_q;
    assign be          = be_q;

endmodule

// File: tb/tb_data_io_ram.sv
// Bench for data_io_ram: a DW=16 and a DW=32 instance share one SPI link;
// expected RAM writes are queued as bytes are sent and compared on each ack.
module tb_data_io_ram;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic ss = 1'b1;
    logic sdi = 1'b0;

    logic        dl16, ov16, req16;
    logic        ack16 = 1'b0;
    logic [24:0] size16, a16;
    logic [4:0]  idx16;
    logic [15:0] d16;
    logic [1:0]  be16;

    logic        dl32, ov32, req32;
    logic        ack32 = 1'b0;
    logic [24:0] size32, a32;
    logic [4:0]  idx32;
    logic [31:0] d32;
    logic [3:0]  be32;

    always #5 clk = ~clk;

    data_io_ram #(
        .DW(16), .AW(25), .BASE(25'hA0000), .IDX_W(5), .FIFO_DEPTH(4)
    ) u_dut16 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl16), .size(size16), .index(idx16), .overrun(ov16),
        .wr_req(req16), .wr_ack(ack16), .a(a16), .d(d16), .be(be16)
    );

    data_io_ram #(
        .DW(32), .AW(25), .BASE(25'hA0000), .IDX_W(5), .FIFO_DEPTH(4)
    ) u_dut32 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl32), .size(size32), .index(idx32), .overrun(ov32),
        .wr_req(req32), .wr_ack(ack32), .a(a32), .d(d32), .be(be32)
    );

    typedef struct {
        logic [24:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  data;
        logic [24:0] exp_size;
        logic [4:0]  exp_idx;
        logic        exp_dl;
    } vec_t;

    wr_t         q16[$];
    wr_t         q32[$];
    int          checks = 0;
    int          failures = 0;
    int          nwr16 = 0;
    logic        ack_en16 = 1'b1;
    logic        ack_en32 = 1'b1;

    // reference model of the packer, one slot per instance (0: DW=16, 1: DW=32)
    logic        m_dl[2];
    int unsigned m_cnt[2];
    int unsigned m_lane[2];
    logic [31:0] m_word[2];
    int unsigned m_lanes[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_write(input int k);
        wr_t e;
        logic bad;
        checks++;
        if (k == 0) begin
            if (q16.size() == 0) begin
                failures++;
                $display("FAIL write16: unexpected a=%h d=%h be=%h, expected none", a16, d16, be16);
            end else begin
                e = q16.pop_front();
                bad = (a16 !== e.a) || (d16 !== e.d[15:0]) || (be16 !== e.be[1:0]);
                if (bad) begin
                    failures++;
                    $display("FAIL write16: got a=%h d=%h be=%h, expected a=%h d=%h be=%h",
                             a16, d16, be16, e.a, e.d[15:0], e.be[1:0]);
                end
            end
            nwr16++;
            check("dl16_during_write", {31'd0, dl16}, 32'd1);
        end else begin
            if (q32.size() == 0) begin
                failures++;
                $display("FAIL write32: unexpected a=%h d=%h be=%h, expected none", a32, d32, be32);
            end else begin
                e = q32.pop_front();
                bad = (a32 !== e.a) || (d32 !== e.d) || (be32 !== e.be);
                if (bad) begin
                    failures++;
                    $display("FAIL write32: got a=%h d=%h be=%h, expected a=%h d=%h be=%h",
                             a32, d32, be32, e.a, e.d, e.be);
                end
            end
            check("dl32_during_write", {31'd0, dl32}, 32'd1);
        end
    endtask

    // one clock step: drive acks at the falling edge and score accepted words
    task automatic tick();
        @(negedge clk);
        ack16 = ack_en16 && req16;
        ack32 = ack_en32 && req32;
        if (ack16) check_write(0);
        if (ack32) check_write(1);
    endtask

    task automatic push_exp(input int k, input int unsigned off, input logic [31:0] w, input logic [3:0] b);
        wr_t e;
        e.a  = 25'(32'hA0000 + off);
        e.d  = w;
        e.be = b;
        if (k == 0) q16.push_back(e);
        else        q32.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_dl[k]   = 1'b0;
            m_cnt[k]  = 0;
            m_lane[k] = 0;
            m_word[k] = '0;
        end
    endtask

    task automatic model_byte(input logic [7:0] cmd, input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            if (cmd == 8'h53 && b[0]) begin
                m_dl[k] = 1'b1; m_cnt[k] = 0; m_lane[k] = 0; m_word[k] = '0;
            end else if (cmd == 8'h53 && m_dl[k]) begin
                m_dl[k] = 1'b0;
                if (m_lane[k] != 0)
                    push_exp(k, m_cnt[k] - m_lane[k], m_word[k], 4'((1 << m_lane[k]) - 1));
            end else if (cmd == 8'h54 && m_dl[k]) begin
                m_word[k][8*m_lane[k] +: 8] = b;
                m_cnt[k]++;
                m_lane[k]++;
                if (m_lane[k] == m_lanes[k]) begin
                    push_exp(k, m_cnt[k] - m_lanes[k], m_word[k], 4'((1 << m_lanes[k]) - 1));
                    m_word[k] = '0;
                    m_lane[k] = 0;
                end
            end
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sdi = b[i];
            repeat (4) tick();
            sck = 1'b1;
            repeat (4) tick();
            sck = 1'b0;
        end
    endtask

    task automatic spi_begin();
        ss = 1'b0;
        repeat (4) tick();
    endtask

    task automatic spi_end();
        repeat (4) tick();
        ss = 1'b1;
        repeat (6) tick();
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] b);
        spi_begin();
        spi_bits(cmd, 8);
        model_byte(cmd, b);
        spi_bits(b, 8);
        spi_end();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (dl16 || dl32); i++) tick();
        check("idle_after_drain", {30'd0, dl16, dl32}, 32'd0);
        check("drained16", q16.size(), 32'd0);
        check("drained32", q32.size(), 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_dl16",   {31'd0, dl16},  32'd0);
        check("rst_size16", {7'd0, size16}, 32'd0);
        check("rst_idx16",  {27'd0, idx16}, 32'd0);
        check("rst_ov16",   {31'd0, ov16},  32'd0);
        check("rst_req16",  {31'd0, req16}, 32'd0);
        check("rst_a16",    {7'd0, a16},    32'h000A0000);
        check("rst_d16",    {16'd0, d16},   32'd0);
        check("rst_be16",   {30'd0, be16},  32'd0);
        check("rst_req32",  {31'd0, req32}, 32'd0);
        check("rst_a32",    {7'd0, a32},    32'h000A0000);
        check("rst_be32",   {28'd0, be32},  32'd0);
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{8'h55, 8'h2A, 25'd0, 5'h0A, 1'b0};
        tbl[1] = '{8'h54, 8'h99, 25'd0, 5'h0A, 1'b0};
        tbl[2] = '{8'h53, 8'h01, 25'd0, 5'h0A, 1'b1};
        tbl[3] = '{8'h54, 8'h11, 25'd1, 5'h0A, 1'b1};
        tbl[4] = '{8'h54, 8'h22, 25'd2, 5'h0A, 1'b1};
        tbl[5] = '{8'h54, 8'h33, 25'd3, 5'h0A, 1'b1};
        tbl[6] = '{8'h54, 8'h44, 25'd4, 5'h0A, 1'b1};
        tbl[7] = '{8'h53, 8'h00, 25'd4, 5'h0A, 1'b0};
        m_lanes[0] = 2;
        m_lanes[1] = 4;
        model_reset();

        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        check_reset_state();

        // index, data-before-start, then a 4-byte download
        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i].cmd, tbl[i].data);
            check("tbl_size16", {7'd0, size16}, {7'd0, tbl[i].exp_size});
            check("tbl_size32", {7'd0, size32}, {7'd0, tbl[i].exp_size});
            check("tbl_idx16",  {27'd0, idx16}, {27'd0, tbl[i].exp_idx});
            check("tbl_dl16",   {31'd0, dl16},  {31'd0, tbl[i].exp_dl});
            check("tbl_dl32",   {31'd0, dl32},  {31'd0, tbl[i].exp_dl});
        end
        wait_idle();

        // five bytes in one transaction: trailing partial word
        xfer(8'h53, 8'h01);
        spi_begin();
        spi_bits(8'h54, 8);
        for (int i = 1; i <= 5; i++) begin
            model_byte(8'h54, 8'(i));
            spi_bits(8'(i), 8);
        end
        spi_end();
        xfer(8'h53, 8'h00);
        wait_idle();
        check("size32_5", {7'd0, size32}, 32'd5);
        check("size16_5", {7'd0, size16}, 32'd5);

        // ss raised mid-byte: the partial byte must be discarded
        xfer(8'h53, 8'h01);
        spi_begin();
        spi_bits(8'h54, 8);
        spi_bits(8'hFF, 5);
        spi_end();
        xfer(8'h54, 8'h77);
        xfer(8'h53, 8'h00);
        wait_idle();
        check("abort_size16", {7'd0, size16}, 32'd1);

        // overrun: RAM stalled, six words streamed into a depth-4 FIFO
        ack_en16 = 1'b0;
        xfer(8'h53, 8'h01);
        spi_begin();
        spi_bits(8'h54, 8);
        for (int i = 0; i < 12; i++) begin
            model_byte(8'h54, 8'hA0 + 8'(i));
            spi_bits(8'hA0 + 8'(i), 8);
        end
        spi_end();
        check("ov16_set",   {31'd0, ov16},  32'd1);
        check("ov32_clear", {31'd0, ov32},  32'd0);
        check("req16_held", {31'd0, req16}, 32'd1);
        void'(q16.pop_back());
        nwr16 = 0;
        ack_en16 = 1'b1;
        xfer(8'h53, 8'h00);
        wait_idle();
        check("ov_writes16", nwr16, 32'd5);
        check("ov16_sticky", {31'd0, ov16}, 32'd1);
        xfer(8'h53, 8'h01);
        check("ov16_cleared", {31'd0, ov16}, 32'd0);
        xfer(8'h53, 8'h00);
        wait_idle();

        // reset while a word is held in the output register
        ack_en16 = 1'b0;
        xfer(8'h53, 8'h01);
        spi_begin();
        spi_bits(8'h54, 8);
        model_byte(8'h54, 8'hC1);
        spi_bits(8'hC1, 8);
        model_byte(8'h54, 8'hC2);
        spi_bits(8'hC2, 8);
        spi_end();
        check("req16_pre_reset", {31'd0, req16}, 32'd1);
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        q16.delete();
        q32.delete();
        model_reset();
        ack_en16 = 1'b1;
        tick();

        // fresh download after reset starts again at BASE
        xfer(8'h53, 8'h01);
        spi_begin();
        spi_bits(8'h54, 8);
        for (int i = 0; i < 3; i++) begin
            model_byte(8'h54, 8'hAA + 8'(17 * i));
            spi_bits(8'hAA + 8'(17 * i), 8);
        end
        spi_end();
        xfer(8'h53, 8'h00);
        wait_idle();
        check("post_reset_size16", {7'd0, size16}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
